// File: rtl/four_bit_pingpong_buffer_if.sv
// Handshake and bank-output bundle between a producer/consumer and the ping-pong buffer.
interface four_bit_pingpong_buffer_if #(
  parameter int unsigned DATA_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  out_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] bank_0;
  logic [DATA_WIDTH-1:0] bank_1;
  logic                  select;
  logic [1:0]            count;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_valid, bank_0, bank_1, select, count
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_valid, bank_0, bank_1, select, count
  );
endinterface

// File: rtl/four_bit_pingpong_buffer.sv
// Two-entry ping-pong buffer feeding a 2x1 mux: banks are written alternately and
// select always points at the oldest unread word.
module four_bit_pingpong_buffer #(
  parameter int unsigned DATA_WIDTH = 4
) (
  input logic                      clk,
  input logic                      rst_n,
  four_bit_pingpong_buffer_if.slave bus
);

  localparam int unsigned DW = DATA_WIDTH;

  logic [1:0]    full_q,  full_d;
  logic          wr_sel_q, wr_sel_d;
  logic          sel_q,   sel_d;
  logic [DW-1:0] bank0_q, bank0_d;
  logic [DW-1:0] bank1_q, bank1_d;
  logic          in_ready_q,  in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [1:0]    count_q,     count_d;
  logic          wr_fire, rd_fire;

  // Handshakes qualify only against registered flags, so no input reaches an output.
  assign wr_fire = bus.in_valid  && in_ready_q;
  assign rd_fire = bus.out_ready && out_valid_q;

  // Next-state: read frees the selected bank, write fills the write-pointer bank.
  // The two never collide since a writable bank is empty and a readable one is full.
  always_comb begin
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    sel_d    = sel_q;
    bank0_d  = bank0_q;
    bank1_d  = bank1_q;

    if (rd_fire) begin
      full_d[sel_q] = 1'b0;
      sel_d         = ~sel_q;
    end

    if (wr_fire) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
      if (wr_sel_q) bank1_d = bus.in_data;
      else          bank0_d = bus.in_data;
    end

    in_ready_d  = ~full_d[wr_sel_d];
    out_valid_d = full_d[sel_d];
    count_d     = 2'(full_d[0]) + 2'(full_d[1]);
  end

  // State and status flags, registered together so status always matches state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q      <= '0;
      wr_sel_q    <= 1'b0;
      sel_q       <= 1'b0;
      bank0_q     <= '0;
      bank1_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      count_q     <= '0;
    end else begin
      full_q      <= full_d;
      wr_sel_q    <= wr_sel_d;
      sel_q       <= sel_d;
      bank0_q     <= bank0_d;
      bank1_q     <= bank1_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.count     = count_q;
  assign bus.select    = sel_q;
  assign bus.bank_0    = bank0_q;
  assign bus.bank_1    = bank1_q;

endmodule

// File: tb/tb_four_bit_pingpong_buffer.sv
// Scoreboard bench for the ping-pong buffer against a two-deep FIFO reference model.
module tb_four_bit_pingpong_buffer;

  logic clk;
  logic rst_n;

  four_bit_pingpong_buffer_if #(.DATA_WIDTH(4)) bus ();

  four_bit_pingpong_buffer #(.DATA_WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a FIFO of capacity two; writes land in banks 0,1,0,1,... after reset.
  logic [3:0]  fifo[$];
  logic [3:0]  exp_q[$];
  logic [3:0]  m_bank[2];
  int unsigned wr_cnt;
  int unsigned rd_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    fifo.delete();
    exp_q.delete();
    m_bank[0] = '0;
    m_bank[1] = '0;
    wr_cnt = 0;
    rd_cnt = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".count"},     int'(bus.count),     fifo.size());
    chk({tag, ".in_ready"},  int'(bus.in_ready),  (fifo.size() < 2) ? 1 : 0);
    chk({tag, ".out_valid"}, int'(bus.out_valid), (fifo.size() > 0) ? 1 : 0);
    chk({tag, ".bank_0"},    int'(bus.bank_0),    int'(m_bank[0]));
    chk({tag, ".bank_1"},    int'(bus.bank_1),    int'(m_bank[1]));
    chk({tag, ".select"},    int'(bus.select),    int'(rd_cnt % 2));
  endtask

  // Present inputs for one edge, advance the model, then check the resulting state.
  task automatic step(input string tag, input logic v, input logic [3:0] d, input logic r);
    bit do_rd;
    bit do_wr;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    do_rd = r && (fifo.size() > 0);
    do_wr = v && (fifo.size() < 2);
    if (do_rd) begin
      exp_q.push_back(fifo.pop_front());
      rd_cnt++;
    end
    if (do_wr) begin
      fifo.push_back(d);
      m_bank[wr_cnt % 2] = d;
      wr_cnt++;
    end
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  // Monitor: each consumer handshake must deliver the next expected word.
  always @(negedge clk) begin
    logic [3:0] got;
    if (rst_n) begin
      if (bus.count != 2'd0) chk("invariant_valid", int'(bus.out_valid), 1);
      if (bus.out_valid && bus.out_ready) begin
        got = bus.select ? bus.bank_1 : bus.bank_0;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL data: got %0h expected none (unexpected read) at %0t", got, $time);
        end else begin
          chk("data", int'(got), int'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 4'h0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    #2 rst_n = 1'b1;

    // Idle after reset.
    step("idle", 1'b0, 4'h0, 1'b0);

    // Fill with A then 5, no reads.
    step("fill_a", 1'b1, 4'hA, 1'b0);
    step("fill_5", 1'b1, 4'h5, 1'b0);

    // From full: In_Valid held with F and a one-cycle read; write lands the following edge.
    step("full_rd", 1'b1, 4'hF, 1'b1);
    step("refill",  1'b1, 4'hF, 1'b0);

    // Drain.
    step("drain0", 1'b0, 4'h0, 1'b1);
    step("drain1", 1'b0, 4'h0, 1'b1);

    // Underflow: reads while empty change nothing.
    for (int i = 0; i < 3; i++) step("underflow", 1'b0, 4'h0, 1'b1);

    // Streaming: count stays at one after the first fill.
    for (int i = 1; i <= 4; i++) step("stream", 1'b1, 4'(i), 1'b1);
    step("stream_end", 1'b0, 4'h0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)));

    // Fill, then async reset between edges.
    step("pre_rst0", 1'b1, 4'h7, 1'b0);
    step("pre_rst1", 1'b1, 4'h9, 1'b0);
    step("pre_rst2", 1'b1, 4'hC, 1'b0);
    chk("pre_rst.count", int'(bus.count), 2);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_state("async_rst");
    #3 rst_n = 1'b1;

    // First write after release goes to bank 0.
    step("post_rst", 1'b1, 4'h3, 1'b0);
    chk("post_rst.bank0_is_3", int'(bus.bank_0), 3);
    step("post_rst_rd", 1'b0, 4'h0, 1'b1);
    step("final_idle", 1'b0, 4'h0, 1'b0);

    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/four_bit_pingpong_buffer.md
Name: four_bit_pingpong_buffer

Overview:
- Two-entry ping-pong (double) buffer that sits directly upstream of the 4-bit 2x1 mux.
- Accepts a stream of 4-bit words over a valid/ready handshake and stores them alternately in two bank registers.
- Drives the mux data inputs (Bank_1 -> In_1, Bank_0 -> In_0) and its Select line so that the mux output always presents the oldest unread word.
- Decouples the producer from the consumer by up to two words.

Parameters:
- DATA_WIDTH, 4, width of each bank and of the data path; must be >= 1.

Ports:
- Clock  input  1  rising-edge clock
- Reset_n  input  1  asynchronous active-low reset
- In_Data  input  DATA_WIDTH  write data from the producer
- In_Valid  input  1  producer has a word on In_Data
- In_Ready  output  1  buffer can accept a word this cycle
- Out_Ready  input  1  consumer takes the word currently selected by the mux
- Out_Valid  output  1  the selected bank holds an unread word
- Bank_0  output  DATA_WIDTH  bank 0 register; connects to mux In_0
- Bank_1  output  DATA_WIDTH  bank 1 register; connects to mux In_1
- Select  output  1  read pointer; connects to mux Select
- Count  output  2  number of unread words, 0..2

Behaviour:
- Clock and reset: one clock domain, Clock. Reset_n is asynchronous and active-low; assertion clears all state immediately, independent of Clock.
- Internal state:
  - Full_0, Full_1: per-bank full flags.
  - Wr_Sel: write pointer.
  - Select: read pointer.
  - Bank_0, Bank_1: data registers.
- Reset values:
  - Bank_0 = 0, Bank_1 = 0.
  - Full_0 = 0, Full_1 = 0.
  - Wr_Sel = 0, Select = 0, Count = 0.
  - Out_Valid = 0, In_Ready = 1.
- Combinational outputs, decoded from registered state only, with no input-to-output paths:
  - In_Ready = !Full[Wr_Sel]
  - Out_Valid = Full[Select]
  - Count = Full_0 + Full_1
- Write:
  - Trigger: on a rising edge with In_Valid && In_Ready.
  - Bank[Wr_Sel] <= In_Data, Full[Wr_Sel] <= 1, Wr_Sel toggles.
  - In_Valid while In_Ready = 0 is ignored; no state change.
  - The producer holds its data until the handshake completes.
- Read:
  - Trigger: on a rising edge with Out_Valid && Out_Ready.
  - Full[Select] <= 0, Select toggles.
  - Bank data is not cleared on read; the stale value remains on the bank output.
  - Out_Ready while Out_Valid = 0 is ignored; Select holds.
- Latency: a word accepted at edge N appears on its bank output at edge N. Out_Valid rises after edge N when that bank is the selected one. Minimum in-to-out latency is 1 cycle.
- Simultaneous read and write in the same cycle:
  - Both are performed.
  - Count is unchanged when exactly one bank was full.
  - When both banks are full, In_Ready = 0, so the write is refused even if a read completes that cycle. There is no pass-through.
  - When the buffer is empty, Out_Valid = 0, so only the write happens.
- Ordering: words leave in strict arrival order.
  - Pointers wrap 1 -> 0.
  - Select always equals the bank of the oldest unread word, or the next bank to be written when empty.
- Full: Count = 2, In_Ready = 0, both banks hold data, Select points at the older word.
- Empty: Count = 0, Out_Valid = 0, Select == Wr_Sel.
- Reset mid-operation: all words are discarded and outputs return to their reset values immediately. The first write after release goes to bank 0.
- Invariant (verification assertion): Count != 0 implies Full[Select] = 1.

Test Plan:
- Reset, then idle -> Bank_0 = Bank_1 = 0, Select = 0, Count = 0, Out_Valid = 0, In_Ready = 1.
- Write 4'hA, then 4'h5, with Out_Ready = 0 -> Bank_0 = A, Bank_1 = 5, Count = 2, In_Ready = 0, Select = 0, Out_Valid = 1.
- From full, hold In_Valid = 1 with 4'hF and pulse Out_Ready for 1 cycle -> read only: Count = 1, Select = 1, In_Ready = 1. 4'hF is written on the next edge into bank 0 -> Count = 2, Bank_0 = F.
- Streaming: In_Valid = Out_Ready = 1 every cycle, data 1,2,3,4 -> after first fill, Count stays 1. Select toggles each cycle. Selected bank value sequence is 1,2,3,4 with no loss or duplication.
- Underflow: Out_Ready = 1 while empty for 3 cycles -> Select and Count unchanged, no toggle.
- Async reset mid-stream: assert Reset_n low between edges with Count = 2 -> outputs clear without a clock edge. After release, write 4'h3 -> lands in Bank_0, Select = 0.
